// File: rtl/l2_line_client_pkg.sv
// Shared types and constants for the L2 line client: FSM states, beat geometry
// and memory request opcodes.
package l2_line_client_pkg;

    localparam int unsigned TAG_W       = 5;
    localparam int unsigned BEAT_W      = 128;
    localparam int unsigned BEATS       = 4;
    localparam int unsigned BEAT_IDX_W  = 2;
    localparam int unsigned LINE_ADDR_W = 12;
    localparam int unsigned LINE_W      = BEAT_W * BEATS;
    localparam int unsigned MEM_ADDR_W  = LINE_ADDR_W + BEAT_IDX_W;
    localparam int unsigned RW_W        = 2;

    localparam logic [RW_W-1:0] RW_LOAD4 = 2'b00;
    localparam logic [RW_W-1:0] RW_STORE = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_BEAT = 3'd3,
        RESP    = 3'd4
    } state_e;

endpackage

// File: rtl/l2_line_beat_buf.sv
// Four-entry beat register file: indexed write, whole-buffer clear, flat line read.
module l2_line_beat_buf
    import l2_line_client_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [BEAT_IDX_W-1:0] wr_idx,
    input  logic [BEAT_W-1:0]     wr_data,
    output logic [LINE_W-1:0]     rd_line
);

    logic [BEAT_W-1:0] beat_q [BEATS];
    logic [BEAT_W-1:0] beat_d [BEATS];

    // Clear wins over a same-cycle write.
    always_comb begin
        for (int i = 0; i < BEATS; i++) begin
            beat_d[i] = beat_q[i];
            if (clr) begin
                beat_d[i] = '0;
            end else if (wr_en && (wr_idx == BEAT_IDX_W'(i))) begin
                beat_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BEATS; i++) begin
            if (!reset_n) begin
                beat_q[i] <= '0;
            end else begin
                beat_q[i] <= beat_d[i];
            end
        end
    end

    always_comb begin
        rd_line = '0;
        for (int i = 0; i < BEATS; i++) begin
            rd_line[i*BEAT_W +: BEAT_W] = beat_q[i];
        end
    end

endmodule

// File: rtl/l2_line_client.sv
// Splits 512-bit line reads/writes into four 128-bit memory beats; reads are
// reassembled by tag and reissued whole on a nack.
module l2_line_client
    import l2_line_client_pkg::*;
#(
    parameter logic [TAG_W-1:0] TAG_ID = 5'd0
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   line_req_val,
    output logic                   line_req_rdy,
    input  logic                   line_req_rw,
    input  logic [LINE_ADDR_W-1:0] line_req_addr,
    input  logic [LINE_W-1:0]      line_req_data,

    output logic                   line_resp_val,
    output logic [LINE_W-1:0]      line_resp_data,

    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic [RW_W-1:0]        mem_req_rw,
    output logic [MEM_ADDR_W-1:0]  mem_req_addr,
    output logic [BEAT_W-1:0]      mem_req_data,
    output logic [TAG_W-1:0]       mem_req_tag,

    input  logic                   mem_resp_val,
    input  logic                   mem_resp_nack,
    input  logic [BEAT_W-1:0]      mem_resp_data,
    input  logic [TAG_W-1:0]       mem_resp_tag
);

    state_e                  state_q, state_d;
    logic [BEAT_IDX_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LINE_ADDR_W-1:0]  line_addr_q, line_addr_d;
    logic [LINE_W-1:0]       line_data_q, line_data_d;
    logic                    line_req_rdy_q, line_req_rdy_d;
    logic                    line_resp_val_q, line_resp_val_d;
    logic [LINE_W-1:0]       line_resp_data_q, line_resp_data_d;
    logic                    mem_req_val_q, mem_req_val_d;
    logic [RW_W-1:0]         mem_req_rw_q, mem_req_rw_d;
    logic [MEM_ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic [BEAT_W-1:0]       mem_req_data_q, mem_req_data_d;

    logic                    buf_clr;
    logic                    buf_wr_en;
    logic [LINE_W-1:0]       buf_line;
    logic                    resp_hit;
    logic                    req_acc;
    logic                    mem_hs;

    assign resp_hit = mem_resp_val && (mem_resp_tag == TAG_ID);
    assign req_acc  = line_req_val && line_req_rdy_q;
    assign mem_hs   = mem_req_val_q && mem_req_rdy;

    l2_line_beat_buf u_beat_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr_en),
        .wr_idx  (beat_cnt_q),
        .wr_data (mem_resp_data),
        .rd_line (buf_line)
    );

    // Next state; memory-side outputs are registered from the next-state view.
    always_comb begin
        state_d          = state_q;
        beat_cnt_d       = beat_cnt_q;
        line_addr_d      = line_addr_q;
        line_data_d      = line_data_q;
        line_resp_data_d = line_resp_data_q;
        buf_clr          = 1'b0;
        buf_wr_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_acc) begin
                    line_addr_d = line_req_addr;
                    line_data_d = line_req_data;
                    beat_cnt_d  = '0;
                    if (line_req_rw) begin
                        state_d = WR_BEAT;
                    end else begin
                        state_d = RD_REQ;
                        buf_clr = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (mem_hs) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (resp_hit) begin
                    if (mem_resp_nack) begin
                        beat_cnt_d = '0;
                        buf_clr    = 1'b1;
                        state_d    = RD_REQ;
                    end else begin
                        buf_wr_en  = 1'b1;
                        beat_cnt_d = beat_cnt_q + 2'd1;
                        if (beat_cnt_q == 2'd3) begin
                            // Last beat bypasses the buffer so the line is valid in RESP.
                            line_resp_data_d = buf_line;
                            line_resp_data_d[BEAT_W*(BEATS-1) +: BEAT_W] = mem_resp_data;
                            state_d = RESP;
                        end
                    end
                end
            end
            WR_BEAT: begin
                if (mem_hs) begin
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == 2'd3) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_req_val_d   = (state_d == RD_REQ) || (state_d == WR_BEAT);
        mem_req_rw_d    = (state_d == WR_BEAT) ? RW_STORE : RW_LOAD4;
        mem_req_addr_d  = {line_addr_d, beat_cnt_d};
        mem_req_data_d  = line_data_d[BEAT_W*beat_cnt_d +: BEAT_W];
        line_req_rdy_d  = (state_d == IDLE);
        line_resp_val_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            beat_cnt_q       <= '0;
            line_addr_q      <= '0;
            line_data_q      <= '0;
            line_req_rdy_q   <= 1'b1;
            line_resp_val_q  <= 1'b0;
            line_resp_data_q <= '0;
            mem_req_val_q    <= 1'b0;
            mem_req_rw_q     <= RW_LOAD4;
            mem_req_addr_q   <= '0;
            mem_req_data_q   <= '0;
        end else begin
            state_q          <= state_d;
            beat_cnt_q       <= beat_cnt_d;
            line_addr_q      <= line_addr_d;
            line_data_q      <= line_data_d;
            line_req_rdy_q   <= line_req_rdy_d;
            line_resp_val_q  <= line_resp_val_d;
            line_resp_data_q <= line_resp_data_d;
            mem_req_val_q    <= mem_req_val_d;
            mem_req_rw_q     <= mem_req_rw_d;
            mem_req_addr_q   <= mem_req_addr_d;
            mem_req_data_q   <= mem_req_data_d;
        end
    end

    assign line_req_rdy   = line_req_rdy_q;
    assign line_resp_val  = line_resp_val_q;
    assign line_resp_data = line_resp_data_q;
    assign mem_req_val    = mem_req_val_q;
    assign mem_req_rw     = mem_req_rw_q;
    assign mem_req_addr   = mem_req_addr_q;
    assign mem_req_data   = mem_req_data_q;
    assign mem_req_tag    = TAG_ID;

endmodule

// File: tb/tb_l2_line_client.sv
// Directed bench for l2_line_client: a default-tag instance and a TAG_ID=3
// instance share stimulus, with sel3 steering requests and observed outputs.
module tb_l2_line_client;

    logic         clk;
    logic         reset_n;
    logic         sel3;
    logic         line_req_val;
    logic         line_req_rw;
    logic [11:0]  line_req_addr;
    logic [511:0] line_req_data;
    logic         mem_req_rdy;
    logic         mem_resp_val;
    logic         mem_resp_nack;
    logic [127:0] mem_resp_data;
    logic [4:0]   mem_resp_tag;

    logic         rdy0, rdy3, rv0, rv3, mv0, mv3;
    logic [511:0] rd0, rd3;
    logic [1:0]   mrw0, mrw3;
    logic [13:0]  ma0, ma3;
    logic [127:0] md0, md3;
    logic [4:0]   mt0, mt3;

    logic         o_rdy, o_rv, o_mv;
    logic [511:0] o_rd;
    logic [1:0]   o_mrw;
    logic [13:0]  o_ma;
    logic [127:0] o_md;
    logic [4:0]   o_mt;

    int n_checks;
    int n_fail;

    logic [127:0] wr_beats [4];

    l2_line_client u_dut0 (
        .clk (clk), .reset_n (reset_n),
        .line_req_val (line_req_val & ~sel3), .line_req_rdy (rdy0),
        .line_req_rw (line_req_rw), .line_req_addr (line_req_addr),
        .line_req_data (line_req_data),
        .line_resp_val (rv0), .line_resp_data (rd0),
        .mem_req_val (mv0), .mem_req_rdy (mem_req_rdy), .mem_req_rw (mrw0),
        .mem_req_addr (ma0), .mem_req_data (md0), .mem_req_tag (mt0),
        .mem_resp_val (mem_resp_val), .mem_resp_nack (mem_resp_nack),
        .mem_resp_data (mem_resp_data), .mem_resp_tag (mem_resp_tag)
    );

    l2_line_client #(.TAG_ID(5'd3)) u_dut3 (
        .clk (clk), .reset_n (reset_n),
        .line_req_val (line_req_val & sel3), .line_req_rdy (rdy3),
        .line_req_rw (line_req_rw), .line_req_addr (line_req_addr),
        .line_req_data (line_req_data),
        .line_resp_val (rv3), .line_resp_data (rd3),
        .mem_req_val (mv3), .mem_req_rdy (mem_req_rdy), .mem_req_rw (mrw3),
        .mem_req_addr (ma3), .mem_req_data (md3), .mem_req_tag (mt3),
        .mem_resp_val (mem_resp_val), .mem_resp_nack (mem_resp_nack),
        .mem_resp_data (mem_resp_data), .mem_resp_tag (mem_resp_tag)
    );

    assign o_rdy = sel3 ? rdy3 : rdy0;
    assign o_rv  = sel3 ? rv3  : rv0;
    assign o_rd  = sel3 ? rd3  : rd0;
    assign o_mv  = sel3 ? mv3  : mv0;
    assign o_mrw = sel3 ? mrw3 : mrw0;
    assign o_ma  = sel3 ? ma3  : ma0;
    assign o_md  = sel3 ? md3  : md0;
    assign o_mt  = sel3 ? mt3  : mt0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a line request for one cycle; returns at the first cycle after acceptance.
    task automatic line_req(input logic rw, input logic [11:0] addr, input logic [511:0] data);
        line_req_val  = 1'b1;
        line_req_rw   = rw;
        line_req_addr = addr;
        line_req_data = data;
        tick();
        line_req_val  = 1'b0;
    endtask

    task automatic beat(input logic [4:0] tag, input logic [127:0] d, input logic nack);
        mem_resp_val  = 1'b1;
        mem_resp_tag  = tag;
        mem_resp_data = d;
        mem_resp_nack = nack;
        tick();
        mem_resp_val  = 1'b0;
        mem_resp_nack = 1'b0;
    endtask

    function automatic logic [511:0] line4(input logic [127:0] b3, input logic [127:0] b2,
                                           input logic [127:0] b1, input logic [127:0] b0);
        return {b3, b2, b1, b0};
    endfunction

    task automatic check_store(input string tag, input logic [13:0] addr, input logic [127:0] data);
        check({tag, "_val"},  512'(o_mv),  512'(1'b1));
        check({tag, "_rw"},   512'(o_mrw), 512'(2'b01));
        check({tag, "_addr"}, 512'(o_ma),  512'(addr));
        check({tag, "_data"}, 512'(o_md),  512'(data));
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        sel3          = 1'b0;
        line_req_val  = 1'b0;
        line_req_rw   = 1'b0;
        line_req_addr = '0;
        line_req_data = '0;
        mem_req_rdy   = 1'b1;
        mem_resp_val  = 1'b0;
        mem_resp_nack = 1'b0;
        mem_resp_data = '0;
        mem_resp_tag  = '0;
        wr_beats[0]   = {4{32'h0000_000A}};
        wr_beats[1]   = {4{32'h0000_000B}};
        wr_beats[2]   = {4{32'h0000_000C}};
        wr_beats[3]   = {4{32'h0000_000D}};

        // Reset state
        repeat (2) tick();
        check("rst_mem_val",   512'(o_mv), 512'(1'b0));
        check("rst_resp_val",  512'(o_rv), 512'(1'b0));
        check("rst_resp_data", o_rd, 512'(0));
        reset_n = 1'b1;
        tick();
        check("rst_rdy", 512'(o_rdy), 512'(1'b1));

        // Read 0x0A5, beats 1..4 on tag 0
        line_req(1'b0, 12'h0A5, '0);
        check("rd_val",  512'(o_mv),  512'(1'b1));
        check("rd_rw",   512'(o_mrw), 512'(2'b00));
        check("rd_addr", 512'(o_ma),  512'(14'h0294));
        check("rd_tag",  512'(o_mt),  512'(5'd0));
        check("rd_rdy_busy", 512'(o_rdy), 512'(1'b0));
        tick();
        check("rd_wait_noreq", 512'(o_mv), 512'(1'b0));
        beat(5'd0, 128'd1, 1'b0);
        beat(5'd0, 128'd2, 1'b0);
        beat(5'd0, 128'd3, 1'b0);
        check("rd_nopulse_early", 512'(o_rv), 512'(1'b0));
        beat(5'd0, 128'd4, 1'b0);
        check("rd_resp_val",  512'(o_rv), 512'(1'b1));
        check("rd_resp_data", o_rd, line4(128'd4, 128'd3, 128'd2, 128'd1));
        tick();
        check("rd_resp_once", 512'(o_rv), 512'(1'b0));
        check("rd_resp_hold", o_rd, line4(128'd4, 128'd3, 128'd2, 128'd1));

        // Write 0xFFF, back-to-back beats at T+1..T+4, response at T+5
        line_req(1'b1, 12'hFFF, line4(wr_beats[3], wr_beats[2], wr_beats[1], wr_beats[0]));
        for (int i = 0; i < 4; i++) begin
            check_store($sformatf("wr_b%0d", i), 14'(14'h3FFC + i), wr_beats[i]);
            tick();
        end
        check("wr_resp_val", 512'(o_rv), 512'(1'b1));
        check("wr_req_idle", 512'(o_mv), 512'(1'b0));
        tick();
        check("wr_resp_once", 512'(o_rv), 512'(1'b0));
        check("wr_keeps_line", o_rd, line4(128'd4, 128'd3, 128'd2, 128'd1));

        // Write 0x123 with rdy low for 2 cycles at beat 1
        line_req(1'b1, 12'h123, line4(128'h44, 128'h33, 128'h22, 128'h11));
        check_store("st_b0", 14'h048C, 128'h11);
        tick();
        check_store("st_b1a", 14'h048D, 128'h22);
        mem_req_rdy = 1'b0;
        tick();
        check_store("st_b1b", 14'h048D, 128'h22);
        tick();
        check_store("st_b1c", 14'h048D, 128'h22);
        mem_req_rdy = 1'b1;
        tick();
        check_store("st_b2", 14'h048E, 128'h33);
        tick();
        check_store("st_b3", 14'h048F, 128'h44);
        tick();
        check("st_resp_val", 512'(o_rv), 512'(1'b1));
        tick();

        // TAG_ID=3 instance, tag-7 beats interleaved
        sel3 = 1'b1;
        line_req(1'b0, 12'h010, '0);
        check("tg_addr", 512'(o_ma), 512'(14'h0040));
        check("tg_tag",  512'(o_mt), 512'(5'd3));
        tick();
        beat(5'd3, 128'h11, 1'b0);
        beat(5'd7, 128'h99, 1'b0);
        beat(5'd3, 128'h12, 1'b0);
        beat(5'd7, 128'h98, 1'b0);
        beat(5'd3, 128'h13, 1'b0);
        check("tg_nopulse", 512'(o_rv), 512'(1'b0));
        beat(5'd3, 128'h14, 1'b0);
        check("tg_resp_val",  512'(o_rv), 512'(1'b1));
        check("tg_resp_data", o_rd, line4(128'h14, 128'h13, 128'h12, 128'h11));
        tick();
        sel3 = 1'b0;
        check("tg_other_idle", 512'(o_rv), 512'(1'b0));

        // Read 0x321 with nack on beat 2
        line_req(1'b0, 12'h321, '0);
        check("nk_addr", 512'(o_ma), 512'(14'h0C84));
        tick();
        beat(5'd0, 128'h21, 1'b0);
        beat(5'd0, 128'h22, 1'b0);
        beat(5'd0, 128'hBAD, 1'b1);
        check("nk_reissue_val",  512'(o_mv),  512'(1'b1));
        check("nk_reissue_addr", 512'(o_ma),  512'(14'h0C84));
        check("nk_reissue_rw",   512'(o_mrw), 512'(2'b00));
        check("nk_nopulse",      512'(o_rv),  512'(1'b0));
        tick();
        beat(5'd0, 128'h31, 1'b0);
        beat(5'd0, 128'h32, 1'b0);
        beat(5'd0, 128'h33, 1'b0);
        check("nk_nopulse3", 512'(o_rv), 512'(1'b0));
        beat(5'd0, 128'h34, 1'b0);
        check("nk_resp_val",  512'(o_rv), 512'(1'b1));
        check("nk_resp_data", o_rd, line4(128'h34, 128'h33, 128'h32, 128'h31));
        tick();

        // Reset during RD_WAIT after 2 beats
        line_req(1'b0, 12'h055, '0);
        tick();
        beat(5'd0, 128'h51, 1'b0);
        beat(5'd0, 128'h52, 1'b0);
        reset_n = 1'b0;
        tick();
        check("rs_resp_val", 512'(o_rv), 512'(1'b0));
        check("rs_mem_val",  512'(o_mv), 512'(1'b0));
        reset_n = 1'b1;
        tick();
        check("rs_rdy", 512'(o_rdy), 512'(1'b1));
        beat(5'd0, 128'h53, 1'b0);
        check("rs_late1", 512'(o_rv), 512'(1'b0));
        beat(5'd0, 128'h54, 1'b0);
        check("rs_late2", 512'(o_rv), 512'(1'b0));
        tick();
        check("rs_late3",     512'(o_rv), 512'(1'b0));
        check("rs_resp_data", o_rd, 512'(0));
        check("rs_rdy_after", 512'(o_rdy), 512'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_line_client.md
L2_LINE_CLIENT -- requirements
Module: l2_line_client

Interface
REQ-001 SHALL have parameter TAG_ID, default 5'd0, the tag this client places on every memory request and matches on responses.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: line_req_val in 1; line_req_rdy out 1; line_req_rw in 1 (0 = read line, 1 = write line); line_req_addr in 12 (line address); line_req_data in 512 (write data, beat0 in [127:0]).
REQ-004 SHALL have ports: line_resp_val out 1 (one-cycle completion pulse for reads and writes); line_resp_data out 512 (read line, beat0 in [127:0]).
REQ-005 SHALL have ports: mem_req_val out 1; mem_req_rdy in 1; mem_req_rw out 2; mem_req_addr out 14 (128-bit word address); mem_req_data out 128; mem_req_tag out 5.
REQ-006 SHALL have ports: mem_resp_val in 1; mem_resp_nack in 1; mem_resp_data in 128; mem_resp_tag in 5.

Function
REQ-007 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_BEAT and RESP, registered, with IDLE as the reset state.
REQ-008 line_req_rdy SHALL be 1 only in IDLE; a line request is accepted when line_req_val & line_req_rdy, and addr, rw and data are captured in that cycle.
REQ-009 IDLE SHALL go to RD_REQ on an accepted read and to WR_BEAT on an accepted write, so mem_req_val rises in the cycle after acceptance.
REQ-010 RD_REQ SHALL drive mem_req_val=1, rw=2'b00, addr={line_addr,2'b00} and tag=TAG_ID, holding them stable until mem_req_val & mem_req_rdy, then go to RD_WAIT.
REQ-011 RD_WAIT SHALL store each mem_resp_val beat with mem_resp_tag==TAG_ID into slot beat_cnt (0..3), then increment beat_cnt; after slot 3 it SHALL go to RESP.
REQ-012 A response with a non-matching tag SHALL be ignored in every state; any response in IDLE, RD_REQ or WR_BEAT SHALL be ignored.
REQ-013 In RD_WAIT, mem_resp_val & mem_resp_nack with a matching tag SHALL discard the beat, clear beat_cnt to 0 and return to RD_REQ to reissue the whole load.
REQ-014 WR_BEAT SHALL drive mem_req_val=1, rw=2'b01, addr={line_addr,beat_cnt}, data=line_data[128*beat_cnt +: 128] and tag=TAG_ID.
REQ-015 In WR_BEAT, beat_cnt SHALL advance only on mem_req_rdy; acceptance of beat 3 SHALL go to RESP. Back-to-back beats are legal, and rdy low stalls with all outputs held.
REQ-016 Stores SHALL expect no response, and mem_resp_nack SHALL have no effect outside RD_WAIT.
REQ-017 RESP SHALL assert line_resp_val for exactly one cycle, then go to IDLE; line_resp_data SHALL hold the assembled line from RESP until the next read completes.
REQ-018 mem_req_val SHALL be 0 in IDLE, RD_WAIT and RESP; the block SHALL have at most one line transaction outstanding.
REQ-019 beat_cnt SHALL be 2 bits, SHALL wrap 3->0 only on a state exit, and address arithmetic SHALL be concatenation with no carry into line_addr.
REQ-020 Minimum latency SHALL be: read, acceptance at cycle T, mem request at T+1, line_resp_val 1 cycle after the 4th beat; write, with mem_req_rdy held high, beats at T+1..T+4 and line_resp_val at T+5.

Reset
REQ-021 While reset_n=0 at a clk edge: state=IDLE, beat_cnt=0, mem_req_val=0, line_resp_val=0, line_resp_data=0, captured address and data=0; line_req_rdy SHALL read 1 from the first cycle after reset is released.
REQ-022 Reset mid-transaction SHALL abandon it without a line_resp_val pulse, and late memory beats for it SHALL be ignored per REQ-012.

Structure
REQ-023 A shared package SHALL hold the state enum and the constants TAG_W=5, BEAT_W=128, BEATS=4, LINE_ADDR_W=12, RW_LOAD4=2'b00 and RW_STORE=2'b01.
REQ-024 Beat storage SHALL be one sub-module, l2_line_beat_buf: a 4x128 register file with indexed write, clear and a 512-bit flat read.

Verification
REQ-025 Read addr 12'h0A5 with the responder returning beats 1,2,3,4 on tag 0 -> one mem request rw=00 addr 14'h0294, then line_resp_data={4,3,2,1} and a single line_resp_val pulse.
REQ-026 Write addr 12'hFFF with data beats A,B,C,D and mem_req_rdy high -> stores at 14'h3FFC..3FFF carrying A..D on consecutive cycles, then line_resp_val at T+5.
REQ-027 Write with mem_req_rdy low for 2 cycles at beat 1 -> beat 1's addr and data held for 3 cycles, with no skipped or duplicated beat.
REQ-028 Read with TAG_ID=5'd3 while tag-7 beats are interleaved -> the tag-7 beats are ignored and the line holds only the tag-3 data.
REQ-029 Read with a nack on beat 2 -> the load is reissued at the same address, and only the 4 beats after the reissue form the line.
REQ-030 reset_n low during RD_WAIT after 2 beats -> no line_resp_val pulse, the next two beats are ignored, and line_req_rdy=1 after reset is released.
